// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: oversampled input, 3-vote majority per bit,
// optional parity, 1 or 2 stop bits, with parity/framing/break reporting.
module uart_rx_cfg #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 smp_tick_i,
    input  logic                 rxd_i,
    output logic [DATA_BITS-1:0] rxd_data_o,
    output logic                 rxd_flag_o,
    output logic                 parity_err_o,
    output logic                 frame_err_o,
    output logic                 break_o
);

    localparam int unsigned CntW = $clog2(OVERSAMPLE);
    localparam int unsigned BitW = 4;
    localparam logic [CntW-1:0] VoteA   = CntW'(OVERSAMPLE / 2 - 1);
    localparam logic [CntW-1:0] VoteB   = CntW'(OVERSAMPLE / 2);
    localparam logic [CntW-1:0] VoteC   = CntW'(OVERSAMPLE / 2 + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e                state_q, state_d;
    logic                  rxd_meta_q, rxd_s_q;
    logic [CntW-1:0]       smp_cnt_q, smp_cnt_d;
    logic [BitW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [1:0]            vote_q, vote_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic                  par_bit_q, par_bit_d;
    logic                  ferr_acc_q, ferr_acc_d;
    logic [DATA_BITS-1:0]  data_q, data_d;
    logic                  flag_q, flag_d;
    logic                  perr_q, perr_d;
    logic                  ferr_q, ferr_d;
    logic                  brk_q, brk_d;

    logic tick_mid, tick_end, maj, ferr_final;

    assign tick_mid = smp_tick_i && (smp_cnt_q == VoteC);
    assign tick_end = smp_tick_i && (smp_cnt_q == CntLast);
    // Third vote is the live synchronised sample on the H+1 tick.
    assign maj = (vote_q[0] & vote_q[1]) | (vote_q[0] & rxd_s_q) | (vote_q[1] & rxd_s_q);
    assign ferr_final = ferr_acc_q | ~maj;

    always_comb begin
        state_d    = state_q;
        smp_cnt_d  = smp_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        vote_d     = vote_q;
        shift_d    = shift_q;
        par_bit_d  = par_bit_q;
        ferr_acc_d = ferr_acc_q;
        data_d     = data_q;
        flag_d     = 1'b0;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        brk_d      = brk_q;

        if (state_q != StIdle && smp_tick_i) begin
            smp_cnt_d = (smp_cnt_q == CntLast) ? '0 : smp_cnt_q + 1'b1;
            if (smp_cnt_q == VoteA) vote_d[0] = rxd_s_q;
            if (smp_cnt_q == VoteB) vote_d[1] = rxd_s_q;
        end

        unique case (state_q)
            StIdle: begin
                smp_cnt_d  = '0;
                bit_cnt_d  = '0;
                vote_d     = '0;
                ferr_acc_d = 1'b0;
                if (!rxd_s_q) state_d = StStart;
            end
            StStart: begin
                if (tick_mid && maj) begin
                    state_d = StIdle;
                end else if (tick_end) begin
                    state_d   = StData;
                    bit_cnt_d = '0;
                end
            end
            StData: begin
                if (tick_mid) begin
                    for (int i = 0; i < DATA_BITS; i++) begin
                        if (bit_cnt_q == BitW'(i)) shift_d[i] = maj;
                    end
                end
                if (tick_end) begin
                    if (bit_cnt_q == BitW'(DATA_BITS - 1)) begin
                        state_d   = (PARITY_EN != 0) ? StParity : StStop;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            StParity: begin
                if (tick_mid) par_bit_d = maj;
                if (tick_end) begin
                    state_d   = StStop;
                    bit_cnt_d = '0;
                end
            end
            StStop: begin
                if (tick_mid) begin
                    if (bit_cnt_q == BitW'(STOP_BITS - 1)) begin
                        // Finish on the last stop bit's centre so a new start edge is not missed.
                        state_d = StIdle;
                        data_d  = shift_q;
                        flag_d  = 1'b1;
                        ferr_d  = ferr_final;
                        perr_d  = (PARITY_EN != 0) &&
                                  (((^shift_q) ^ par_bit_q) != (PARITY_ODD != 0));
                        brk_d   = ferr_final && (shift_q == '0) &&
                                  ((PARITY_EN == 0) || !par_bit_q);
                    end else begin
                        ferr_acc_d = ferr_final;
                    end
                end
                if (tick_end) bit_cnt_d = bit_cnt_q + 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            rxd_meta_q <= 1'b1;
            rxd_s_q    <= 1'b1;
            smp_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            vote_q     <= '0;
            shift_q    <= '0;
            par_bit_q  <= 1'b0;
            ferr_acc_q <= 1'b0;
            data_q     <= '0;
            flag_q     <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            brk_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rxd_meta_q <= rxd_i;
            rxd_s_q    <= rxd_meta_q;
            smp_cnt_q  <= smp_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            vote_q     <= vote_d;
            shift_q    <= shift_d;
            par_bit_q  <= par_bit_d;
            ferr_acc_q <= ferr_acc_d;
            data_q     <= data_d;
            flag_q     <= flag_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            brk_q      <= brk_d;
        end
    end

    assign rxd_data_o   = data_q;
    assign rxd_flag_o   = flag_q;
    assign parity_err_o = perr_q;
    assign frame_err_o  = ferr_q;
    assign break_o      = brk_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: 8N1, 7O1 and 8N2 instances on a shared clock and tick.
module tb_uart_rx_cfg;

    logic clk, rst_n, tick;
    logic rxd_a, rxd_b, rxd_c;
    logic [7:0] data_a, data_c;
    logic [6:0] data_b;
    logic flag_a, perr_a, ferr_a, brk_a;
    logic flag_b, perr_b, ferr_b, brk_b;
    logic flag_c, perr_c, ferr_c, brk_c;

    int errors = 0;
    int checks = 0;
    int flag_cnt [3];
    logic [8:0] last_data [3];
    logic last_perr [3];
    logic last_ferr [3];
    logic last_brk [3];
    int div = 0;

    uart_rx_cfg u_dut_a (
        .clk(clk), .rst_n(rst_n), .smp_tick_i(tick), .rxd_i(rxd_a),
        .rxd_data_o(data_a), .rxd_flag_o(flag_a), .parity_err_o(perr_a),
        .frame_err_o(ferr_a), .break_o(brk_a)
    );

    uart_rx_cfg #(.DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .smp_tick_i(tick), .rxd_i(rxd_b),
        .rxd_data_o(data_b), .rxd_flag_o(flag_b), .parity_err_o(perr_b),
        .frame_err_o(ferr_b), .break_o(brk_b)
    );

    uart_rx_cfg #(.STOP_BITS(2)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .smp_tick_i(tick), .rxd_i(rxd_c),
        .rxd_data_o(data_c), .rxd_flag_o(flag_c), .parity_err_o(perr_c),
        .frame_err_o(ferr_c), .break_o(brk_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One tick every 4 clk, changed on the falling edge so it is stable at posedge.
    initial tick = 1'b0;
    always @(negedge clk) begin
        div  <= (div == 3) ? 0 : div + 1;
        tick <= (div == 3);
    end

    initial begin
        for (int i = 0; i < 3; i++) flag_cnt[i] = 0;
    end

    always @(negedge clk) begin
        if (flag_a) begin
            flag_cnt[0]  <= flag_cnt[0] + 1;
            last_data[0] <= {1'b0, data_a};
            last_perr[0] <= perr_a; last_ferr[0] <= ferr_a; last_brk[0] <= brk_a;
        end
        if (flag_b) begin
            flag_cnt[1]  <= flag_cnt[1] + 1;
            last_data[1] <= {2'b00, data_b};
            last_perr[1] <= perr_b; last_ferr[1] <= ferr_b; last_brk[1] <= brk_b;
        end
        if (flag_c) begin
            flag_cnt[2]  <= flag_cnt[2] + 1;
            last_data[2] <= {1'b0, data_c};
            last_perr[2] <= perr_c; last_ferr[2] <= ferr_c; last_brk[2] <= brk_c;
        end
    end

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (tick !== 1'b1) @(posedge clk);
        end
        #1;
    endtask

    task automatic set_line(input int sel, input logic v);
        case (sel)
            0: rxd_a = v;
            1: rxd_b = v;
            default: rxd_c = v;
        endcase
    endtask

    task automatic send_frame(input int sel, input logic [8:0] data, input int nbits,
                              input bit par_en, input bit par_bit, input int nstop,
                              input bit stop_last);
        set_line(sel, 1'b0);
        wait_ticks(16);
        for (int i = 0; i < nbits; i++) begin
            set_line(sel, data[i]);
            wait_ticks(16);
        end
        if (par_en) begin
            set_line(sel, par_bit);
            wait_ticks(16);
        end
        for (int s = 0; s < nstop; s++) begin
            set_line(sel, (s == nstop - 1) ? stop_last : 1'b1);
            wait_ticks(16);
        end
        set_line(sel, 1'b1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rxd_a = 1'b1; rxd_b = 1'b1; rxd_c = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checks++; if (data_a !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", data_a); end
        checks++; if (flag_a !== 1'b0) begin errors++; $display("FAIL reset_flag: got %b want 0", flag_a); end
        checks++; if ({perr_a, ferr_a, brk_a} !== 3'b000) begin
            errors++; $display("FAIL reset_errs: got %b want 000", {perr_a, ferr_a, brk_a});
        end
        checks++; if ({data_b, data_c} !== 15'h0) begin
            errors++; $display("FAIL reset_data_bc: got %h/%h want 0/0", data_b, data_c);
        end
        rst_n = 1'b1;
        wait_ticks(8);
    endtask

    task automatic test_back_to_back();
        int c0;
        logic [7:0] vals [2];
        vals[0] = 8'hA5; vals[1] = 8'h3C;
        c0 = flag_cnt[0];
        for (int k = 0; k < 2; k++) begin
            send_frame(0, {1'b0, vals[k]}, 8, 1'b0, 1'b0, 1, 1'b1);
            checks++; if (flag_cnt[0] !== c0 + k + 1) begin
                errors++; $display("FAIL b2b_flags%0d: got %0d want %0d", k, flag_cnt[0], c0 + k + 1);
            end
            checks++; if (last_data[0] !== {1'b0, vals[k]}) begin
                errors++; $display("FAIL b2b_data%0d: got %h want %h", k, last_data[0], vals[k]);
            end
            checks++; if ({last_perr[0], last_ferr[0], last_brk[0]} !== 3'b000) begin
                errors++; $display("FAIL b2b_errs%0d: got %b want 000", k,
                                   {last_perr[0], last_ferr[0], last_brk[0]});
            end
        end
        wait_ticks(32);
    endtask

    task automatic test_false_start();
        int c0;
        c0 = flag_cnt[0];
        set_line(0, 1'b0);
        wait_ticks(4);
        set_line(0, 1'b1);
        wait_ticks(40);
        checks++; if (flag_cnt[0] !== c0) begin
            errors++; $display("FAIL false_start_noflag: got %0d flags want 0", flag_cnt[0] - c0);
        end
        send_frame(0, 9'h081, 8, 1'b0, 1'b0, 1, 1'b1);
        checks++; if (flag_cnt[0] !== c0 + 1) begin
            errors++; $display("FAIL after_false_flag: got %0d want %0d", flag_cnt[0], c0 + 1);
        end
        checks++; if (last_data[0] !== 9'h081) begin
            errors++; $display("FAIL after_false_data: got %h want 81", last_data[0]);
        end
        wait_ticks(32);
    endtask

    task automatic test_glitch();
        int c0;
        c0 = flag_cnt[0];
        set_line(0, 1'b0);
        wait_ticks(16 + 3 * 16 + 8);
        set_line(0, 1'b1);   // single-tick glitch on the centre vote of data bit 3
        wait_ticks(1);
        set_line(0, 1'b0);
        wait_ticks(7 + 4 * 16);
        set_line(0, 1'b1);
        wait_ticks(16);
        checks++; if (flag_cnt[0] !== c0 + 1) begin
            errors++; $display("FAIL glitch_flag: got %0d want %0d", flag_cnt[0], c0 + 1);
        end
        checks++; if (last_data[0] !== 9'h000) begin
            errors++; $display("FAIL glitch_data: got %h want 00", last_data[0]);
        end
        checks++; if ({last_perr[0], last_ferr[0], last_brk[0]} !== 3'b000) begin
            errors++; $display("FAIL glitch_errs: got %b want 000",
                               {last_perr[0], last_ferr[0], last_brk[0]});
        end
        wait_ticks(32);
    endtask

    task automatic test_parity();
        int c0;
        c0 = flag_cnt[1];
        send_frame(1, 9'h055, 7, 1'b1, 1'b1, 1, 1'b1);
        checks++; if (flag_cnt[1] !== c0 + 1) begin
            errors++; $display("FAIL par_ok_flag: got %0d want %0d", flag_cnt[1], c0 + 1);
        end
        checks++; if (last_data[1] !== 9'h055) begin
            errors++; $display("FAIL par_ok_data: got %h want 55", last_data[1]);
        end
        checks++; if ({last_perr[1], last_ferr[1], last_brk[1]} !== 3'b000) begin
            errors++; $display("FAIL par_ok_errs: got %b want 000",
                               {last_perr[1], last_ferr[1], last_brk[1]});
        end
        send_frame(1, 9'h055, 7, 1'b1, 1'b0, 1, 1'b1);
        checks++; if (flag_cnt[1] !== c0 + 2) begin
            errors++; $display("FAIL par_bad_flag: got %0d want %0d", flag_cnt[1], c0 + 2);
        end
        checks++; if (last_data[1] !== 9'h055) begin
            errors++; $display("FAIL par_bad_data: got %h want 55", last_data[1]);
        end
        checks++; if ({last_perr[1], last_ferr[1], last_brk[1]} !== 3'b100) begin
            errors++; $display("FAIL par_bad_errs: got %b want 100",
                               {last_perr[1], last_ferr[1], last_brk[1]});
        end
        wait_ticks(32);
    endtask

    task automatic test_two_stop();
        int c0;
        c0 = flag_cnt[2];
        send_frame(2, 9'h0F0, 8, 1'b0, 1'b0, 2, 1'b0);
        checks++; if (flag_cnt[2] !== c0 + 1) begin
            errors++; $display("FAIL stop2_flag: got %0d want %0d", flag_cnt[2], c0 + 1);
        end
        checks++; if (last_data[2] !== 9'h0F0) begin
            errors++; $display("FAIL stop2_data: got %h want f0", last_data[2]);
        end
        checks++; if ({last_perr[2], last_ferr[2], last_brk[2]} !== 3'b010) begin
            errors++; $display("FAIL stop2_errs: got %b want 010",
                               {last_perr[2], last_ferr[2], last_brk[2]});
        end
        wait_ticks(48);
        checks++; if (flag_cnt[2] !== c0 + 1) begin
            errors++; $display("FAIL stop2_extra_flag: got %0d want %0d", flag_cnt[2], c0 + 1);
        end
    endtask

    task automatic test_break();
        int c0;
        bit seen;
        logic [8:0] cap_data;
        logic [2:0] cap_errs;
        c0 = flag_cnt[0];
        seen = 1'b0;
        cap_data = 9'h1FF;
        cap_errs = 3'b000;
        set_line(0, 1'b0);
        for (int t = 0; t < 12 * 16; t++) begin
            wait_ticks(1);
            if (!seen && flag_cnt[0] != c0) begin
                seen = 1'b1;
                cap_data = last_data[0];
                cap_errs = {last_perr[0], last_ferr[0], last_brk[0]};
            end
        end
        set_line(0, 1'b1);
        checks++; if (seen !== 1'b1) begin
            errors++; $display("FAIL break_flag: got none want 1 within 12 bits");
        end
        checks++; if (cap_data !== 9'h000) begin
            errors++; $display("FAIL break_data: got %h want 00", cap_data);
        end
        checks++; if (cap_errs !== 3'b011) begin
            errors++; $display("FAIL break_errs: got %b want 011", cap_errs);
        end
        wait_ticks(20 * 16);
    endtask

    task automatic test_reset_mid_frame();
        int c0;
        set_line(0, 1'b0);
        wait_ticks(16 + 4 * 16);
        set_line(0, 1'b1);
        wait_ticks(8);
        rst_n = 1'b0;
        #1;
        checks++; if (data_a !== 8'h00) begin errors++; $display("FAIL midrst_data: got %h want 00", data_a); end
        checks++; if (flag_a !== 1'b0) begin errors++; $display("FAIL midrst_flag: got %b want 0", flag_a); end
        checks++; if ({perr_a, ferr_a, brk_a} !== 3'b000) begin
            errors++; $display("FAIL midrst_errs: got %b want 000", {perr_a, ferr_a, brk_a});
        end
        c0 = flag_cnt[0];
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_ticks(8 + 4 * 16);
        checks++; if (flag_cnt[0] !== c0) begin
            errors++; $display("FAIL midrst_noflag: got %0d flags want 0", flag_cnt[0] - c0);
        end
        send_frame(0, 9'h012, 8, 1'b0, 1'b0, 1, 1'b1);
        checks++; if (flag_cnt[0] !== c0 + 1) begin
            errors++; $display("FAIL postrst_flag: got %0d want %0d", flag_cnt[0], c0 + 1);
        end
        checks++; if (last_data[0] !== 9'h012) begin
            errors++; $display("FAIL postrst_data: got %h want 12", last_data[0]);
        end
        checks++; if ({last_perr[0], last_ferr[0], last_brk[0]} !== 3'b000) begin
            errors++; $display("FAIL postrst_errs: got %b want 000",
                               {last_perr[0], last_ferr[0], last_brk[0]});
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_false_start();
        test_glitch();
        test_parity();
        test_two_stop();
        test_break();
        test_reset_mid_frame();
        wait_ticks(16);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
